// File: rtl/col_weight_accum.sv
// Column-weighted accumulator. It takes one column popcount per valid beat,
// LSB column first, and forms sum(cnt_k * 2^k) over a packet of up to NCOL
// columns. When SIGNED is set, the closing column carries negative weight.
// One registered result is produced per packet, with no dead cycles between
// packets.
module col_weight_accum #(
  parameter int CNT_W  = 8,
  parameter int NCOL   = 16,
  parameter int SIGNED = 0,
  parameter int ACC_W  = CNT_W + NCOL,
  parameter int NC_W   = $clog2(NCOL + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic             in_last,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_sum,
  output logic [NC_W-1:0]  out_ncol,
  output logic             out_err
);

  localparam int IDX_W = (NCOL > 1) ? $clog2(NCOL) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [IDX_W-1:0] idx;

  logic [IDX_W-1:0] idx_cur;
  logic [ACC_W-1:0] cnt_ext;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] sum_next;
  logic [NC_W-1:0]  ncol_next;
  logic             last_col;
  logic             closing;

  // Next-beat datapath. In IDLE the column index is 0 by definition.
  always_comb begin
    idx_cur   = (state == S_ACCUM) ? idx : '0;
    cnt_ext   = ACC_W'(in_cnt);
    term      = cnt_ext << idx_cur;
    last_col  = (idx_cur == IDX_W'(NCOL - 1));
    closing   = in_last | last_col;
    // The closing column is the MSB and takes negative weight in signed mode.
    sum_next  = (closing && (SIGNED != 0)) ? (acc - term) : (acc + term);
    ncol_next = NC_W'(idx_cur) + NC_W'(1);
  end

  // Accumulator/FSM and result registers. rst overrides any beat in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ncol  <= '0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        if (closing) begin
          out_valid <= 1'b1;
          out_sum   <= sum_next;
          out_ncol  <= ncol_next;
          // The packet ran out of columns before in_last arrived.
          out_err   <= last_col & ~in_last;
          acc       <= '0;
          idx       <= '0;
          state     <= S_IDLE;
        end else begin
          acc       <= sum_next;
          idx       <= idx_cur + IDX_W'(1);
          state     <= S_ACCUM;
        end
      end
    end
  end

endmodule
